fir_out_requant: RTL
====================

# fir_out_requant

Downstream stage of the 3-tap FIR filter. Consumes the filter's Q5.10 output sample stream, rounds and saturates each sample back to the Q3.4 sample format, and buffers results in a small FIFO. Results are presented to the next consumer over a valid/ready handshake. Lets the free-running FIR datapath drive a back-pressuring sink without stalling the filter; lost samples are flagged.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, minimum 2.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: `in_data` holds a sample this cycle.
- `in_data` in 16: signed Q5.10 sample from FIR `y`.
- `out_valid` out 1: FIFO head valid.
- `out_data` out 8: signed Q3.4 FIFO head.
- `out_ready` in 1: sink accepts head this cycle.
- `level` out $clog2(DEPTH)+1: current FIFO occupancy.
- `ovf` out 1: sticky, set when a sample is dropped.
- `ovf_clr` in 1: clears `ovf`.

## Operation
- Stage 1, requantize, registered:
  - sum = sign-extend(`in_data`) to 17 b + 17'sd32 (round half toward +inf).
  - q = sum >>> 6, arithmetic shift, 11 b.
  - If q > 127, result = 8'h7F; if q < -128, result = 8'h80; otherwise result = q[7:0].
  - Stage-1 valid register copies `in_valid`.
  - The stage never stalls; it updates every cycle.
- Stage 2, FIFO (`fir_req_fifo`):
  - pop = `out_valid` & `out_ready`.
  - push = s1_valid & (!full | pop).
  - Push and pop in the same cycle is legal, including when full; `level` is unchanged.
  - Full and s1_valid with no pop: the sample is dropped, `ovf` is set, and FIFO contents are unchanged.
  - Pop when empty is impossible because `out_valid` is 0.
  - No fall-through: a sample written into an empty FIFO appears on `out_data` the cycle after the write.
  - Read and write pointers wrap modulo DEPTH. Full/empty are derived from `level` (0 or DEPTH).
- `ovf` priority: a set in the same cycle as `ovf_clr` wins; `ovf` stays 1.
- `out_data` must hold stable while `out_valid` is 1 and `out_ready` is 0.

## Timing
- Reset values (`rst_n` low at a clock edge): `out_valid` 0, `out_data` 8'h00, `level` 0, `ovf` 0, s1_valid 0, pointers 0.
- Reset mid-operation discards all buffered and in-flight samples.
- Latency: `in_valid` sampled at edge N → s1 register at N → FIFO write at N+1 → `out_valid` high after edge N+1 (2 cycles) when the FIFO is empty.
- Throughput: 1 sample/cycle while `out_ready` stays high.
- `level` and `ovf` are registered and update on the same edge as the push/pop that changes them.

## Configuration
- Macro `FIR_REQ_SAT_CNT_EN`.
- Defined: adds output `sat_cnt` (16 b), which counts stage-1 samples that saturated (clipped high or low).
  - Counts only when s1_valid is 1.
  - Saturates at 16'hFFFF; does not wrap.
  - Cleared by reset and by `ovf_clr`.
- Undefined: no `sat_cnt` port and no counter logic. All other behaviour is identical.

## Structure
- Shared package `fir_pkg` holds:
  - Format constants: `FIR_X_W`=8, `FIR_X_FRAC`=4, `FIR_Y_W`=16, `FIR_Y_FRAC`=10.
  - Derived shift `FIR_REQ_SHIFT` = `FIR_Y_FRAC` - `FIR_X_FRAC` = 6.
  - Saturation limits `FIR_X_MAX` = 8'h7F and `FIR_X_MIN` = 8'h80.
- One sub-module, `fir_req_fifo`: parameterized synchronous FIFO (data width, DEPTH) providing push/pop, full/empty and level.
- Requantize logic lives in the top module.

## Test plan
- Reset, then `in_data` = 16'h0800 (2.0) with `out_ready`=1 → `out_data` = 8'h20, `out_valid` rises 2 cycles after `in_valid`.
- Rounding: 16'h0020 → 8'h01; 16'h001F → 8'h00; 16'hFFE0 → 8'h00; 16'hFFDF → 8'hFF.
- Saturation: 16'h7FFF → 8'h7F; 16'h8000 → 8'h80; 16'h2000 (8.0) → 8'h7F. With `FIR_REQ_SAT_CNT_EN` defined, `sat_cnt` = 3 afterwards.
- Back-pressure: `out_ready`=0 with DEPTH=4 and 5 consecutive valid samples → first 4 retained in order, 5th dropped, `level`=4, `ovf`=1. Releasing `out_ready` drains the 4 samples in order.
- Full with push and pop in the same cycle: `level` stays 4, no drop, `ovf` unchanged. `ovf_clr` pulsed alone clears `ovf`; pulsed during a drop leaves `ovf`=1.
- Full FIR sequence 2,4,6,4,2,0,0,0 (Q3.4) through `fir_3tap` into this block → outputs match a golden model bit-exact. Asserting `rst_n` low mid-stream gives `level`=0 and `out_valid`=0 after the next edge.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared fixed-point formats and requantize helpers for the 3-tap FIR.
//   Sample format x : Q3.4  (FIR_X_W bits, FIR_X_FRAC fraction bits)
//   Output format y : Q5.10 (FIR_Y_W bits, FIR_Y_FRAC fraction bits)
//   fir_req_round(y) : y rounded half toward +inf and shifted to x scale,
//                      FIR_REQ_Q_W bits wide.
//   fir_req_is_sat(q): q lies outside the x range.
//   fir_req_clip(q)  : q clipped to FIR_X_MIN..FIR_X_MAX, FIR_X_W bits.
package fir_pkg;

  localparam int FIR_X_W       = 8;
  localparam int FIR_X_FRAC    = 4;
  localparam int FIR_Y_W       = 16;
  localparam int FIR_Y_FRAC    = 10;
  localparam int FIR_REQ_SHIFT = FIR_Y_FRAC - FIR_X_FRAC;

  // Width of the shifted, not yet clipped, value: 17-bit sum minus the shift.
  localparam int FIR_REQ_Q_W   = FIR_Y_W + 1 - FIR_REQ_SHIFT;

  localparam logic [FIR_X_W-1:0] FIR_X_MAX = 8'h7F;
  localparam logic [FIR_X_W-1:0] FIR_X_MIN = 8'h80;

  // Half an output LSB, in y scale.
  localparam logic [FIR_Y_W:0] FIR_REQ_ROUND = (FIR_Y_W + 1)'(1) << (FIR_REQ_SHIFT - 1);

  function automatic logic [FIR_REQ_Q_W-1:0] fir_req_round(input logic [FIR_Y_W-1:0] y);
    logic signed [FIR_Y_W:0] sum;
    // One guard bit so that 0x7FFF + round cannot wrap negative.
    sum = $signed({y[FIR_Y_W-1], y} + FIR_REQ_ROUND);
    return FIR_REQ_Q_W'(sum >>> FIR_REQ_SHIFT);
  endfunction

  // In range exactly when every bit from the x sign bit upward agrees.
  function automatic logic fir_req_is_sat(input logic [FIR_REQ_Q_W-1:0] q);
    return !((&q[FIR_REQ_Q_W-1:FIR_X_W-1]) || !(|q[FIR_REQ_Q_W-1:FIR_X_W-1]));
  endfunction

  function automatic logic [FIR_X_W-1:0] fir_req_clip(input logic [FIR_REQ_Q_W-1:0] q);
    if (fir_req_is_sat(q)) return q[FIR_REQ_Q_W-1] ? FIR_X_MIN : FIR_X_MAX;
    return q[FIR_X_W-1:0];
  endfunction

endpackage

// File: rtl/fir_out_requant_if.sv
// fir_out_requant_if: sample stream into and out of the requantizer.
//   in_valid/in_data   : Q5.10 samples from the FIR (no back-pressure)
//   out_valid/out_ready/out_data : Q3.4 results, valid/ready handshake
//   master : environment side (drives samples, sink ready)
//   slave  : requantizer side
interface fir_out_requant_if;
  import fir_pkg::*;

  logic               in_valid;
  logic [FIR_Y_W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [FIR_X_W-1:0] out_data;

  modport master (output in_valid, in_data, out_ready, input out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output out_valid, out_data);

endinterface

// File: rtl/fir_req_fifo.sv
// fir_req_fifo: synchronous FIFO, no fall-through.
//   push/wdata : write when push (caller guarantees !full or simultaneous pop)
//   pop/rdata  : rdata is the head; pop advances it (caller guarantees !empty)
//   full/empty/level : derived from the registered occupancy
//   rst_n : synchronous, active-low; clears pointers and level.
module fir_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: storage has no reset; an entry is only ever read once level says
  // it was written, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by plain overflow.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  // Masked while empty so the head reads 0 out of reset.
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fir_out_requant.sv
// fir_out_requant: rounds/saturates Q5.10 FIR output to Q3.4 and buffers
// the results in a DEPTH-entry FIFO for a back-pressuring sink.
//   clk, rst_n : single clock, synchronous active-low reset
//   bus        : fir_out_requant_if.slave (input stream, output handshake)
//   level      : FIFO occupancy
//   ovf        : sticky, set when a sample arrives with the FIFO full and
//                no pop; a set beats a simultaneous ovf_clr
//   ovf_clr    : clears ovf (and sat_cnt when present)
//   sat_cnt    : only with FIR_REQ_SAT_CNT_EN defined; saturating count of
//                stage-1 samples that were clipped
module fir_out_requant
  import fir_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fir_out_requant_if.slave        bus,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    ovf,
  input  logic                    ovf_clr
`ifdef FIR_REQ_SAT_CNT_EN
  ,
  output logic [15:0]             sat_cnt
`endif
);

  logic [FIR_REQ_Q_W-1:0] req_q;
  logic                   s1_valid;
  logic [FIR_X_W-1:0]     s1_data;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic                   full;
  logic                   empty;

  assign req_q = fir_req_round(bus.in_data);

  // Stage 1 never stalls; the FIFO absorbs or drops what it produces.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      s1_data  <= fir_req_clip(req_q);
    end
  end

  assign pop  = bus.out_valid & bus.out_ready;
  // A pop frees the slot this same edge, so full does not block the push.
  assign push = s1_valid & (!full | pop);
  assign drop = s1_valid & full & !pop;

  fir_req_fifo #(
    .W     (FIR_X_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (s1_data),
    .pop   (pop),
    .rdata (bus.out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bus.out_valid = !empty;

  always_ff @(posedge clk) begin
    if (!rst_n)       ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

`ifdef FIR_REQ_SAT_CNT_EN
  logic s1_sat;

  always_ff @(posedge clk) begin
    if (!rst_n) s1_sat <= 1'b0;
    else        s1_sat <= fir_req_is_sat(req_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || ovf_clr)
      sat_cnt <= '0;
    else if (s1_valid && s1_sat && sat_cnt != 16'hFFFF)
      sat_cnt <= sat_cnt + 16'd1;
  end
`endif

endmodule
